cpu_control_fsm: RTL

//  Multi-cycle control sequencer for the 16x16 CPU register file and its ALU.

---
 rtl/cpu_control_fsm.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/cpu_control_fsm.sv
// Multi-cycle control sequencer for a 16x16 register file and an external
// combinational ALU. Accepts one instruction per valid/ready handshake and
// steps it through DECODE, EXEC and WRITE. It counts each retired instruction.
module cpu_control_fsm #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  input  logic [DATA_W-1:0] alu_result,
  output logic [2:0]        alu_op,
  output logic [ADDR_W-1:0] read_reg_addr_1,
  output logic [ADDR_W-1:0] read_reg_addr_2,
  output logic              regWrite,
  output logic [ADDR_W-1:0] write_reg_addr,
  output logic [DATA_W-1:0] write_data,
  output logic              done,
  output logic              illegal,
  output logic              halted,
  output logic [CNT_W-1:0]  retired_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WRITE  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_MOV  = 4'h7;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t              state_q, state_d;
  logic [15:0]         ir_q, ir_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [3:0] ir_op;
  assign ir_op = ir_q[15:12];

  // Map an ALU-class opcode onto the external ALU's operation code.
  function automatic logic [2:0] alu_code(input logic [3:0] op);
    case (op)
      OP_ADD:  alu_code = 3'd0;
      OP_SUB:  alu_code = 3'd1;
      OP_AND:  alu_code = 3'd2;
      OP_OR:   alu_code = 3'd3;
      OP_XOR:  alu_code = 3'd4;
      OP_MOV:  alu_code = 3'd5;
      default: alu_code = 3'd0;
    endcase
  endfunction

  // State, instruction, result, write-index and counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      ir_q      <= '0;
      result_q  <= '0;
      wr_addr_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      result_q  <= result_d;
      wr_addr_q <= wr_addr_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state sequencing plus the done/illegal pulses and the ALU opcode.
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    result_d  = result_q;
    wr_addr_d = wr_addr_q;
    done      = 1'b0;
    illegal   = 1'b0;
    alu_op    = 3'd0;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          ir_d    = instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (ir_op)
          OP_NOP: begin
            done    = 1'b1;
            state_d = S_IDLE;
          end
          OP_LDI: begin
            result_d  = DATA_W'(ir_q[7:0]);
            wr_addr_d = ADDR_W'(ir_q[11:8]);
            state_d   = S_WRITE;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_MOV: state_d = S_EXEC;
          OP_HALT: state_d = S_HALTED;
          default: begin
            illegal = 1'b1;
            state_d = S_IDLE;
          end
        endcase
      end
      S_EXEC: begin
        alu_op    = alu_code(ir_op);
        result_d  = alu_result;
        wr_addr_d = ADDR_W'(ir_q[11:8]);
        state_d   = S_WRITE;
      end
      S_WRITE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_IDLE;
    endcase
    // Retired count advances on the same edge that ends a done cycle.
    cnt_d = cnt_q + CNT_W'(done);
  end

  // Read indices come straight from IR so they are stable through DECODE and EXEC;
  // ready is masked while reset is held so every output reads 0 during reset.
  assign instr_ready     = (state_q == S_IDLE) && reset;
  assign halted          = (state_q == S_HALTED);
  assign regWrite        = (state_q == S_WRITE);
  assign read_reg_addr_1 = ADDR_W'(ir_q[7:4]);
  assign read_reg_addr_2 = ADDR_W'(ir_q[3:0]);
  assign write_reg_addr  = wr_addr_q;
  assign write_data      = result_q;
  assign retired_cnt     = cnt_q;

endmodule
